// File: rtl/multi_cycle_control_if.sv
// Control-unit <-> datapath/memory signal bundle for multi_cycle_control.
// The master side is the controller and the slave side is the datapath.
interface multi_cycle_control_if;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic       branch_taken_i;

  logic       pc_write_o;
  logic [1:0] pc_src_o;
  logic       ir_write_o;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       reg_write_o;
  logic       reg_dst_o;
  logic       alu_src_o;
  logic       mem_to_reg_o;
  logic       sin_ext_o;
  logic       link_o;
  logic [2:0] alu_op_o;
  logic [1:0] branch_type_o;
  logic       halted_o;

  modport master (
    input  instr_op_i, mem_ready_i, branch_taken_i,
    output pc_write_o, pc_src_o, ir_write_o, mem_req_o, mem_we_o,
           reg_write_o, reg_dst_o, alu_src_o, mem_to_reg_o, sin_ext_o,
           link_o, alu_op_o, branch_type_o, halted_o
  );

  modport slave (
    output instr_op_i, mem_ready_i, branch_taken_i,
    input  pc_write_o, pc_src_o, ir_write_o, mem_req_o, mem_we_o,
           reg_write_o, reg_dst_o, alu_src_o, mem_to_reg_o, sin_ext_o,
           link_o, alu_op_o, branch_type_o, halted_o
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM with a bounded wait on memory accesses.
//  state  | meaning
//  IDLE   | one cycle after reset before the first fetch
//  FETCH  | instruction read; IR/PC load when memory is ready
//  DECODE | classify opcode; J/JAL complete here
//  EXEC   | ALU operation or branch resolution
//  MEM    | data load/store
//  WB     | register file write
//  ERROR  | illegal opcode or memory timeout; halted until reset
module multi_cycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  multi_cycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_ADDI, C_ORI, C_LUI, C_LW, C_SW, C_BR, C_J, C_JAL, C_BAD
  } cls_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        r_state;
  cls_t          r_cls;
  logic [1:0]    r_br_type;
  logic [CW-1:0] r_wait;

  cls_t       w_cls;
  logic [1:0] w_br_type;
  logic       w_timeout;

  logic [2:0] w_cls_alu_op;
  logic       w_cls_alu_src;
  logic       w_cls_sin_ext;

  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_ir_write;
  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_alu_src;
  logic       w_mem_to_reg;
  logic       w_sin_ext;
  logic       w_link;
  logic [2:0] w_alu_op;
  logic [1:0] w_branch_type;
  logic       w_halted;

  always_comb begin
    w_cls     = C_BAD;
    w_br_type = 2'b00;
    case (bus.instr_op_i)
      6'b000000: w_cls = C_R;
      6'b001000: w_cls = C_ADDI;
      6'b001101: w_cls = C_ORI;
      6'b001111: w_cls = C_LUI;
      6'b100011: w_cls = C_LW;
      6'b101011: w_cls = C_SW;
      6'b000100: begin w_cls = C_BR; w_br_type = 2'b00; end
      6'b000001: begin w_cls = C_BR; w_br_type = 2'b01; end
      6'b000111: begin w_cls = C_BR; w_br_type = 2'b10; end
      6'b000101: begin w_cls = C_BR; w_br_type = 2'b11; end
      6'b000010: w_cls = C_J;
      6'b000011: w_cls = C_JAL;
      default:   w_cls = C_BAD;
    endcase
  end

  // ALU setup chosen in EXEC and held through MEM and WB
  always_comb begin
    w_cls_alu_op  = 3'b000;
    w_cls_alu_src = 1'b0;
    w_cls_sin_ext = 1'b0;
    case (r_cls)
      C_R:               w_cls_alu_op = 3'b010;
      C_ADDI, C_LW, C_SW: begin w_cls_alu_src = 1'b1; w_cls_sin_ext = 1'b1; end
      C_ORI:             begin w_cls_alu_op = 3'b011; w_cls_alu_src = 1'b1; end
      C_LUI:             w_cls_alu_src = 1'b1;
      C_BR:              begin w_cls_alu_op = 3'b001; w_cls_sin_ext = 1'b1; end
      default:           w_cls_alu_op = 3'b000;
    endcase
  end

  // A ready strobe in the last allowed cycle still completes the access
  assign w_timeout = !bus.mem_ready_i && (r_wait == WAIT_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_cls     <= C_BAD;
      r_br_type <= 2'b00;
      r_wait    <= '0;
    end else begin
      r_wait <= '0;
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (bus.mem_ready_i)  r_state <= S_DECODE;
          else if (w_timeout)   r_state <= S_ERROR;
          else                  r_wait  <= r_wait + CW'(1);
        end
        S_DECODE: begin
          r_cls     <= w_cls;
          r_br_type <= w_br_type;
          case (w_cls)
            C_J, C_JAL: r_state <= S_FETCH;
            C_BAD:      r_state <= S_ERROR;
            default:    r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (r_cls)
            C_BR:       r_state <= S_FETCH;
            C_LW, C_SW: r_state <= S_MEM;
            default:    r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready_i)  r_state <= (r_cls == C_LW) ? S_WB : S_FETCH;
          else if (w_timeout)   r_state <= S_ERROR;
          else                  r_wait  <= r_wait + CW'(1);
        end
        S_WB:    r_state <= S_FETCH;
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_ERROR;
      endcase
    end
  end

  always_comb begin
    w_pc_write    = 1'b0;
    w_pc_src      = 2'b00;
    w_ir_write    = 1'b0;
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_reg_write   = 1'b0;
    w_reg_dst     = 1'b0;
    w_alu_src     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_sin_ext     = 1'b0;
    w_link        = 1'b0;
    w_alu_op      = 3'b000;
    w_branch_type = 2'b00;
    w_halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready_i) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_cls == C_J || w_cls == C_JAL) begin
          w_pc_write = 1'b1;
          w_pc_src   = 2'b10;
        end
        if (w_cls == C_JAL) begin
          w_reg_write = 1'b1;
          w_link      = 1'b1;
        end
      end
      S_EXEC: begin
        w_alu_op  = w_cls_alu_op;
        w_alu_src = w_cls_alu_src;
        w_sin_ext = w_cls_sin_ext;
        if (r_cls == C_BR) begin
          w_branch_type = r_br_type;
          w_pc_write    = bus.branch_taken_i;
          w_pc_src      = 2'b01;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (r_cls == C_SW);
        w_alu_op  = w_cls_alu_op;
        w_alu_src = w_cls_alu_src;
        w_sin_ext = w_cls_sin_ext;
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = (r_cls == C_R);
        w_mem_to_reg = (r_cls == C_LW);
        w_alu_op     = w_cls_alu_op;
        w_alu_src    = w_cls_alu_src;
        w_sin_ext    = w_cls_sin_ext;
      end
      S_ERROR: w_halted = 1'b1;
      default: w_halted = 1'b0;
    endcase
  end

  assign bus.pc_write_o    = w_pc_write;
  assign bus.pc_src_o      = w_pc_src;
  assign bus.ir_write_o    = w_ir_write;
  assign bus.mem_req_o     = w_mem_req;
  assign bus.mem_we_o      = w_mem_we;
  assign bus.reg_write_o   = w_reg_write;
  assign bus.reg_dst_o     = w_reg_dst;
  assign bus.alu_src_o     = w_alu_src;
  assign bus.mem_to_reg_o  = w_mem_to_reg;
  assign bus.sin_ext_o     = w_sin_ext;
  assign bus.link_o        = w_link;
  assign bus.alu_op_o      = w_alu_op;
  assign bus.branch_type_o = w_branch_type;
  assign bus.halted_o      = w_halted;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed per-cycle vector bench for multi_cycle_control.
module tb_multi_cycle_control;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       sin_ext;
    logic       link;
    logic [2:0] alu_op;
    logic [1:0] branch_type;
    logic       halted;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic       tk;
    outs_t      exp;
    string      name;
  } vec_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BGEZ = 6'b000001;
  localparam logic [5:0] OP_BGT  = 6'b000111;
  localparam logic [5:0] OP_BNEZ = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  multi_cycle_control_if bus ();

  multi_cycle_control #(.MEM_TIMEOUT(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  outs_t act;
  assign act = {bus.pc_write_o, bus.pc_src_o, bus.ir_write_o, bus.mem_req_o,
                bus.mem_we_o, bus.reg_write_o, bus.reg_dst_o, bus.alu_src_o,
                bus.mem_to_reg_o, bus.sin_ext_o, bus.link_o, bus.alu_op_o,
                bus.branch_type_o, bus.halted_o};

  outs_t ZERO, FW, FG, EX_ADDI, WB_ADDI, EX_R, WB_R, EX_ORI, WB_ORI;
  outs_t EX_LUI, WB_LUI, MEM_LW, WB_LW, MEM_SW;
  outs_t EX_BNEZ_T, EX_BEQ_N, EX_BGT_T, EX_BGEZ_N, DEC_J, DEC_JAL, ERR;

  vec_t tbl[$];

  function automatic void add(input string name, input logic [5:0] op,
                              input logic rdy, input logic tk, input outs_t exp);
    vec_t v;
    v.name = name; v.op = op; v.rdy = rdy; v.tk = tk; v.exp = exp;
    tbl.push_back(v);
  endfunction

  // Drive inputs just after the falling edge, then let outputs settle.
  task automatic drive(input logic [5:0] op, input logic rdy, input logic tk);
    @(negedge clk_i);
    bus.instr_op_i     = op;
    bus.mem_ready_i    = rdy;
    bus.branch_taken_i = tk;
    #1;
  endtask

  task automatic check(input string name, input outs_t exp);
    logic [17:0] a, e;
    a = act;
    e = exp;
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, a, e);
    end
  endtask

  task automatic release_reset();
    @(posedge clk_i);
    #2 rst_i = 1'b1;
  endtask

  task automatic enter_reset(input string name);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 check(name, ZERO);
  endtask

  initial begin
    ZERO = '0;
    FW = '0;        FW.mem_req = 1'b1;
    FG = FW;        FG.ir_write = 1'b1; FG.pc_write = 1'b1;
    EX_ADDI = '0;   EX_ADDI.alu_src = 1'b1; EX_ADDI.sin_ext = 1'b1;
    WB_ADDI = EX_ADDI; WB_ADDI.reg_write = 1'b1;
    EX_R = '0;      EX_R.alu_op = 3'b010;
    WB_R = EX_R;    WB_R.reg_write = 1'b1; WB_R.reg_dst = 1'b1;
    EX_ORI = '0;    EX_ORI.alu_op = 3'b011; EX_ORI.alu_src = 1'b1;
    WB_ORI = EX_ORI; WB_ORI.reg_write = 1'b1;
    EX_LUI = '0;    EX_LUI.alu_src = 1'b1;
    WB_LUI = EX_LUI; WB_LUI.reg_write = 1'b1;
    MEM_LW = EX_ADDI; MEM_LW.mem_req = 1'b1;
    MEM_SW = MEM_LW;  MEM_SW.mem_we = 1'b1;
    WB_LW = WB_ADDI;  WB_LW.mem_to_reg = 1'b1;
    EX_BEQ_N = '0;  EX_BEQ_N.alu_op = 3'b001; EX_BEQ_N.sin_ext = 1'b1;
    EX_BEQ_N.pc_src = 2'b01; EX_BEQ_N.branch_type = 2'b00;
    EX_BNEZ_T = EX_BEQ_N; EX_BNEZ_T.branch_type = 2'b11; EX_BNEZ_T.pc_write = 1'b1;
    EX_BGT_T  = EX_BEQ_N; EX_BGT_T.branch_type  = 2'b10; EX_BGT_T.pc_write  = 1'b1;
    EX_BGEZ_N = EX_BEQ_N; EX_BGEZ_N.branch_type = 2'b01;
    DEC_J = '0;     DEC_J.pc_write = 1'b1; DEC_J.pc_src = 2'b10;
    DEC_JAL = DEC_J; DEC_JAL.reg_write = 1'b1; DEC_JAL.link = 1'b1;
    ERR = '0;       ERR.halted = 1'b1;

    // One row per clock cycle starting at the IDLE cycle after reset release.
    add("idle",        OP_ADDI, 1, 0, ZERO);
    add("addi_fetch",  OP_ADDI, 1, 0, FG);
    add("addi_dec",    OP_ADDI, 1, 0, ZERO);
    add("addi_exec",   OP_ADDI, 1, 0, EX_ADDI);
    add("addi_wb",     OP_ADDI, 1, 0, WB_ADDI);
    add("r_fetch",     OP_R,    1, 0, FG);
    add("r_dec",       OP_R,    1, 0, ZERO);
    add("r_exec",      OP_R,    1, 0, EX_R);
    add("r_wb",        OP_R,    1, 0, WB_R);
    add("ori_fetch",   OP_ORI,  1, 0, FG);
    add("ori_dec",     OP_ORI,  1, 0, ZERO);
    add("ori_exec",    OP_ORI,  1, 0, EX_ORI);
    add("ori_wb",      OP_ORI,  1, 0, WB_ORI);
    add("lui_fetch",   OP_LUI,  1, 0, FG);
    add("lui_dec",     OP_LUI,  1, 0, ZERO);
    add("lui_exec",    OP_LUI,  1, 0, EX_LUI);
    add("lui_wb",      OP_LUI,  1, 0, WB_LUI);
    add("lw_fwait1",   OP_LW,   0, 0, FW);
    add("lw_fwait2",   OP_LW,   0, 0, FW);
    add("lw_fwait3",   OP_LW,   0, 0, FW);
    add("lw_fetch",    OP_LW,   1, 0, FG);
    add("lw_dec",      OP_LW,   1, 0, ZERO);
    add("lw_exec",     OP_LW,   1, 0, EX_ADDI);
    add("lw_mwait1",   OP_LW,   0, 0, MEM_LW);
    add("lw_mwait2",   OP_LW,   0, 0, MEM_LW);
    add("lw_mwait3",   OP_LW,   0, 0, MEM_LW);
    add("lw_mem",      OP_LW,   1, 0, MEM_LW);
    add("lw_wb",       OP_LW,   1, 0, WB_LW);
    add("sw_fetch",    OP_SW,   1, 0, FG);
    add("sw_dec",      OP_SW,   1, 0, ZERO);
    add("sw_exec",     OP_SW,   1, 0, EX_ADDI);
    add("sw_mem",      OP_SW,   1, 0, MEM_SW);
    add("bnez_fetch",  OP_BNEZ, 1, 1, FG);
    add("bnez_dec",    OP_BNEZ, 1, 1, ZERO);
    add("bnez_exec",   OP_BNEZ, 1, 1, EX_BNEZ_T);
    add("beq_fetch",   OP_BEQ,  1, 0, FG);
    add("beq_dec",     OP_BEQ,  1, 0, ZERO);
    add("beq_exec",    OP_BEQ,  1, 0, EX_BEQ_N);
    add("j_fetch",     OP_J,    1, 0, FG);
    add("j_dec",       OP_J,    1, 0, DEC_J);
    add("jal_fetch",   OP_JAL,  1, 0, FG);
    add("jal_dec",     OP_JAL,  1, 0, DEC_JAL);
    add("bgt_fetch",   OP_BGT,  1, 1, FG);
    add("bgt_dec",     OP_BGT,  1, 1, ZERO);
    add("bgt_exec",    OP_BGT,  1, 1, EX_BGT_T);
    add("bgez_fetch",  OP_BGEZ, 1, 0, FG);
    add("bgez_dec",    OP_BGEZ, 1, 0, ZERO);
    add("bgez_exec",   OP_BGEZ, 1, 0, EX_BGEZ_N);
    add("bad_fetch",   OP_BAD,  1, 0, FG);
    add("bad_dec",     OP_BAD,  1, 0, ZERO);
    add("bad_error",   OP_BAD,  0, 0, ERR);
    add("bad_hold",    OP_BAD,  1, 1, ERR);

    bus.instr_op_i     = OP_SW;
    bus.mem_ready_i    = 1'b1;
    bus.branch_taken_i = 1'b1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #7 check("in_reset", ZERO);
    release_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].op, tbl[i].rdy, tbl[i].tk);
      check(tbl[i].name, tbl[i].exp);
    end

    // FETCH timeout: sixteen unready cycles then ERROR
    enter_reset("rst_from_error");
    release_reset();
    drive(OP_ADDI, 0, 0); check("ft_idle", ZERO);
    for (int i = 0; i < 16; i++) begin
      drive(OP_ADDI, 0, 0); check("ft_wait", FW);
    end
    drive(OP_ADDI, 1, 0); check("ft_error", ERR);

    // MEM timeout on LW
    enter_reset("rst_from_ftimeout");
    release_reset();
    drive(OP_LW, 1, 0); check("mt_idle", ZERO);
    drive(OP_LW, 1, 0); check("mt_fetch", FG);
    drive(OP_LW, 1, 0); check("mt_dec", ZERO);
    drive(OP_LW, 1, 0); check("mt_exec", EX_ADDI);
    for (int i = 0; i < 16; i++) begin
      drive(OP_LW, 0, 0); check("mt_wait", MEM_LW);
    end
    drive(OP_LW, 1, 0); check("mt_error", ERR);

    // Ready in the sixteenth MEM cycle wins over the timeout
    enter_reset("rst_from_mtimeout");
    release_reset();
    drive(OP_LW, 1, 0); check("rw_idle", ZERO);
    drive(OP_LW, 1, 0); check("rw_fetch", FG);
    drive(OP_LW, 1, 0); check("rw_dec", ZERO);
    drive(OP_LW, 1, 0); check("rw_exec", EX_ADDI);
    for (int i = 0; i < 15; i++) begin
      drive(OP_LW, 0, 0); check("rw_wait", MEM_LW);
    end
    drive(OP_LW, 1, 0); check("rw_mem_last", MEM_LW);
    drive(OP_LW, 1, 0); check("rw_wb", WB_LW);
    drive(OP_ADDI, 1, 0); check("rw_next_fetch", FG);

    // Reset asserted in the middle of a SW access
    drive(OP_SW, 1, 0); check("rs_dec", ZERO);
    drive(OP_SW, 1, 0); check("rs_exec", EX_ADDI);
    drive(OP_SW, 0, 0); check("rs_mem", MEM_SW);
    #2 rst_i = 1'b0;
    #1 check("rs_mem_dropped", ZERO);
    release_reset();
    drive(OP_SW, 1, 0); check("rs_idle", ZERO);
    drive(OP_SW, 0, 0); check("rs_refetch", FW);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
